// File: rtl/alu_writeback_stage.sv
// Execute/write-back stage behind the 4x4 register file: captures operands on START,
// evaluates (single-cycle ALU op or shift-add MUL), then pulses one register-file write.
module alu_writeback_stage #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [AW-1:0]    RD,
  input  logic [WIDTH-1:0] CRS,
  input  logic [WIDTH-1:0] CRT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DW,
  output logic [AW-1:0]    RW,
  output logic             RG_WE,
  output logic             ZF,
  output logic             CF
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [PW-1:0]    a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;

  logic             exec_done;
  logic [WIDTH-1:0] result;
  logic             carry;

  // Next state, end-of-execute detection and result/flag extraction
  always_comb begin
    state_d   = state_q;
    exec_done = 1'b0;
    result    = acc_q[WIDTH-1:0];
    carry     = 1'b0;
    case (state_q)
      S_IDLE: if (START) state_d = S_EXEC;
      S_EXEC: begin
        exec_done = (op_q == OP_MUL) ? (cnt_q == CW'(WIDTH)) : (cnt_q == CW'(1));
        if (exec_done) state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The upper half of the wide accumulator is nonzero exactly on carry, borrow or MUL overflow
    if (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_MUL) carry = |acc_q[PW-1:WIDTH];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, execute datapath and registered write-back outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q  <= '0;
      rd_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      RG_WE <= 1'b0;
      DW    <= '0;
      RW    <= '0;
      ZF    <= 1'b0;
      CF    <= 1'b0;
    end else begin
      BUSY  <= (state_d != S_IDLE);
      DONE  <= 1'b0;
      RG_WE <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            op_q  <= OP;
            rd_q  <= RD;
            a_q   <= PW'(CRS);
            b_q   <= CRT;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        S_EXEC: begin
          if (!exec_done) begin
            cnt_q <= cnt_q + CW'(1);
            case (op_q)
              OP_ADD: acc_q <= a_q + PW'(b_q);
              OP_SUB: acc_q <= a_q - PW'(b_q);
              OP_AND: acc_q <= a_q & PW'(b_q);
              OP_OR:  acc_q <= a_q | PW'(b_q);
              OP_XOR: acc_q <= a_q ^ PW'(b_q);
              OP_MUL: begin
                // LSB-first shift-add: one multiplier bit per cycle
                if (b_q[0]) acc_q <= acc_q + a_q;
                a_q <= a_q << 1;
                b_q <= b_q >> 1;
              end
              OP_SLT:  acc_q <= {{(PW-1){1'b0}}, (a_q < PW'(b_q))};
              default: acc_q <= acc_q;
            endcase
          end else begin
            DONE <= 1'b1;
            if (op_q != OP_NOP) begin
              RG_WE <= 1'b1;
              DW    <= result;
              RW    <= rd_q;
              ZF    <= (result == '0);
              CF    <= carry;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed spec cases plus random ops checked
// against an arithmetic reference model of the register-file write stream.
module tb_alu_writeback_stage;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] dw;
    logic       cf;
  } vec_t;

  logic       CLK;
  logic       RST;
  logic       START;
  logic [2:0] OP;
  logic [1:0] RD;
  logic [3:0] CRS;
  logic [3:0] CRT;
  logic       BUSY;
  logic       DONE;
  logic [3:0] DW;
  logic [1:0] RW;
  logic       RG_WE;
  logic       ZF;
  logic       CF;

  int vectors;
  int miscompares;

  // Reference model state: last architectural write and flags
  logic [3:0] exp_dw;
  logic [1:0] exp_rw;
  logic       exp_zf;
  logic       exp_cf;
  logic       exp_we;
  int         exp_lat;

  // Observations collected by run_op
  int         obs_lat;
  logic       obs_we;
  logic [3:0] obs_dw;
  logic [1:0] obs_rw;
  logic       obs_zf;
  logic       obs_cf;
  logic       obs_busy_wb;
  logic       obs_early;
  logic       obs_busy_drop;
  logic [2:0] obs_after;

  alu_writeback_stage #(.WIDTH(4), .AW(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .RD(RD), .CRS(CRS), .CRT(CRT),
    .BUSY(BUSY), .DONE(DONE), .DW(DW), .RW(RW), .RG_WE(RG_WE), .ZF(ZF), .CF(CF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_apply(input logic [2:0] op, input logic [1:0] rd,
                             input logic [3:0] a, input logic [3:0] b);
    int unsigned ua, ub, r;
    bit c;
    ua = a; ub = b; r = 0; c = 0;
    case (op)
      3'd0: begin r = ua + ub; c = (r >= 16); end
      3'd1: begin r = ua + 16 - ub; c = (ua < ub); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin r = ua * ub; c = (r >= 16); end
      3'd6: r = (ua < ub) ? 1 : 0;
      default: ;
    endcase
    exp_we  = (op != 3'd7);
    exp_lat = (op == 3'd5) ? W + 1 : 2;
    if (op != 3'd7) begin
      exp_dw = 4'(r % 16);
      exp_rw = rd;
      exp_zf = ((r % 16) == 0);
      exp_cf = c;
    end
  endtask

  // Issue one op, wait (bounded) for DONE, record the WB cycle and the cycle after it
  task automatic run_op(input logic [2:0] op, input logic [1:0] rd,
                        input logic [3:0] a, input logic [3:0] b, input bit noise);
    obs_lat = 0; obs_early = 0; obs_busy_drop = 0;
    OP = op; RD = rd; CRS = a; CRT = b; START = 1'b1;
    tick();
    START = 1'b0;
    OP = 3'($urandom); RD = 2'($urandom); CRS = 4'($urandom); CRT = 4'($urandom);
    for (int c = 1; c <= 20; c++) begin
      if (noise) START = 1'($urandom);
      tick();
      if (DONE) begin
        obs_lat = c;
        break;
      end
      if (RG_WE) obs_early = 1'b1;
      if (!BUSY) obs_busy_drop = 1'b1;
    end
    START = 1'b0;
    obs_we = RG_WE; obs_dw = DW; obs_rw = RW; obs_zf = ZF; obs_cf = CF; obs_busy_wb = BUSY;
    tick();
    obs_after = {DONE, RG_WE, BUSY};
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; OP = '0; RD = '0; CRS = '0; CRT = '0;
    tick(); tick();
    vectors++;
    if ({BUSY, DONE, RG_WE, ZF, CF, DW, RW} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required all zero", {BUSY, DONE, RG_WE, ZF, CF, DW, RW});
    end
    RST = 1'b0;
    tick();
    vectors++;
    if ({BUSY, DONE, RG_WE} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_idle: busy/done/we %b required 000", {BUSY, DONE, RG_WE});
    end
  endtask

  task automatic test_add_sub();
    vec_t tbl[3];
    tbl = '{'{3'd0, 2'd2, 4'd9, 4'd8, 4'd1, 1'b1},
            '{3'd1, 2'd0, 4'd3, 4'd5, 4'd14, 1'b1},
            '{3'd1, 2'd3, 4'd5, 4'd5, 4'd0, 1'b0}};
    foreach (tbl[i]) begin
      model_apply(tbl[i].op, tbl[i].rd, tbl[i].a, tbl[i].b);
      run_op(tbl[i].op, tbl[i].rd, tbl[i].a, tbl[i].b, 1'b0);
      vectors++;
      if (obs_lat != 2) begin
        miscompares++;
        $display("FAIL addsub_latency[%0d]: got %0d cycles required 2", i, obs_lat);
      end
      vectors++;
      if ({obs_we, obs_dw, obs_rw, obs_zf, obs_cf} !== {1'b1, tbl[i].dw, tbl[i].rd, (tbl[i].dw == 4'd0), tbl[i].cf}) begin
        miscompares++;
        $display("FAIL addsub_result[%0d]: we/dw/rw/zf/cf got %b/%0d/%0d/%b/%b required 1/%0d/%0d/%b/%b", i,
                 obs_we, obs_dw, obs_rw, obs_zf, obs_cf, tbl[i].dw, tbl[i].rd, (tbl[i].dw == 4'd0), tbl[i].cf);
      end
      vectors++;
      if ({obs_busy_wb, obs_early, obs_busy_drop, obs_after} !== 6'b100000) begin
        miscompares++;
        $display("FAIL addsub_handshake[%0d]: got %b required 100000", i, {obs_busy_wb, obs_early, obs_busy_drop, obs_after});
      end
    end
  endtask

  task automatic test_mul();
    vec_t tbl[2];
    tbl = '{'{3'd5, 2'd1, 4'd3, 4'd5, 4'd15, 1'b0},
            '{3'd5, 2'd3, 4'd7, 4'd3, 4'd5, 1'b1}};
    foreach (tbl[i]) begin
      model_apply(tbl[i].op, tbl[i].rd, tbl[i].a, tbl[i].b);
      run_op(tbl[i].op, tbl[i].rd, tbl[i].a, tbl[i].b, 1'b1);
      vectors++;
      if (obs_lat != W + 1) begin
        miscompares++;
        $display("FAIL mul_latency[%0d]: got %0d cycles required %0d", i, obs_lat, W + 1);
      end
      vectors++;
      if ({obs_we, obs_dw, obs_rw, obs_zf, obs_cf} !== {1'b1, tbl[i].dw, tbl[i].rd, (tbl[i].dw == 4'd0), tbl[i].cf}) begin
        miscompares++;
        $display("FAIL mul_result[%0d]: we/dw/rw/zf/cf got %b/%0d/%0d/%b/%b required 1/%0d/%0d/%b/%b", i,
                 obs_we, obs_dw, obs_rw, obs_zf, obs_cf, tbl[i].dw, tbl[i].rd, (tbl[i].dw == 4'd0), tbl[i].cf);
      end
      vectors++;
      if ({obs_busy_wb, obs_early, obs_busy_drop, obs_after} !== 6'b100000) begin
        miscompares++;
        $display("FAIL mul_busy_no_extra_write[%0d]: got %b required 100000", i, {obs_busy_wb, obs_early, obs_busy_drop, obs_after});
      end
    end
  endtask

  task automatic test_nop();
    model_apply(3'd7, 2'd1, 4'd6, 4'd6);
    run_op(3'd7, 2'd1, 4'd6, 4'd6, 1'b0);
    vectors++;
    if (obs_lat != 2) begin
      miscompares++;
      $display("FAIL nop_done: got %0d cycles required 2", obs_lat);
    end
    vectors++;
    if ({obs_we, obs_dw, obs_rw, obs_zf, obs_cf} !== {1'b0, exp_dw, exp_rw, exp_zf, exp_cf}) begin
      miscompares++;
      $display("FAIL nop_hold: we/dw/rw/zf/cf got %b/%0d/%0d/%b/%b required 0/%0d/%0d/%b/%b",
               obs_we, obs_dw, obs_rw, obs_zf, obs_cf, exp_dw, exp_rw, exp_zf, exp_cf);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic seen;
    OP = 3'd5; RD = 2'd2; CRS = 4'd7; CRT = 4'd7; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    #2 RST = 1'b1;
    #1;
    vectors++;
    if ({BUSY, DONE, RG_WE, ZF, CF, DW, RW} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_mid_mul_outputs: got %b required all zero", {BUSY, DONE, RG_WE, ZF, CF, DW, RW});
    end
    tick(); tick();
    RST = 1'b0;
    exp_dw = '0; exp_rw = '0; exp_zf = 1'b0; exp_cf = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (RG_WE || DONE || BUSY) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_mul_abort: activity after release got 1 required 0");
    end
    model_apply(3'd0, 2'd3, 4'd1, 4'd1);
    run_op(3'd0, 2'd3, 4'd1, 4'd1, 1'b0);
    vectors++;
    if ({obs_lat == 2, obs_we, obs_dw, obs_rw, obs_zf, obs_cf} !== {1'b1, 1'b1, 4'd2, 2'd3, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_recover_add: lat/we/dw/rw/zf/cf got %0d/%b/%0d/%0d/%b/%b required 2/1/2/3/0/0",
               obs_lat, obs_we, obs_dw, obs_rw, obs_zf, obs_cf);
    end
  endtask

  task automatic test_logic_back_to_back();
    vec_t tbl[5];
    tbl = '{'{3'd2, 2'd0, 4'hC, 4'hA, 4'd8, 1'b0},
            '{3'd3, 2'd1, 4'hC, 4'hA, 4'd14, 1'b0},
            '{3'd4, 2'd2, 4'hC, 4'hA, 4'd6, 1'b0},
            '{3'd6, 2'd3, 4'hC, 4'hA, 4'd0, 1'b0},
            '{3'd6, 2'd1, 4'h2, 4'hF, 4'd1, 1'b0}};
    foreach (tbl[i]) begin
      model_apply(tbl[i].op, tbl[i].rd, tbl[i].a, tbl[i].b);
      run_op(tbl[i].op, tbl[i].rd, tbl[i].a, tbl[i].b, 1'b0);
      vectors++;
      if ({obs_lat == 2, obs_we, obs_dw, obs_rw, obs_zf, obs_cf} !== {1'b1, 1'b1, tbl[i].dw, tbl[i].rd, (tbl[i].dw == 4'd0), tbl[i].cf}) begin
        miscompares++;
        $display("FAIL logic_b2b[%0d]: lat/we/dw/rw/zf/cf got %0d/%b/%0d/%0d/%b/%b required 2/1/%0d/%0d/%b/%b", i,
                 obs_lat, obs_we, obs_dw, obs_rw, obs_zf, obs_cf, tbl[i].dw, tbl[i].rd, (tbl[i].dw == 4'd0), tbl[i].cf);
      end
    end
  endtask

  task automatic test_start_in_wb();
    logic seen;
    model_apply(3'd4, 2'd1, 4'd5, 4'd5);
    OP = 3'd4; RD = 2'd1; CRS = 4'd5; CRT = 4'd5; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick();
    vectors++;
    if ({DONE, RG_WE, DW, RW, ZF} !== {1'b1, 1'b1, 4'd0, 2'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL wb_xor_zero: done/we/dw/rw/zf got %b/%b/%0d/%0d/%b required 1/1/0/1/1", DONE, RG_WE, DW, RW, ZF);
    end
    OP = 3'd0; RD = 2'd2; CRS = 4'd1; CRT = 4'd1; START = 1'b1;
    tick();
    START = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (BUSY || DONE || RG_WE) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_wb_ignored: activity got 1 required 0");
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [1:0] rd;
    logic [3:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7)); rd = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
      model_apply(op, rd, a, b);
      run_op(op, rd, a, b, 1'($urandom));
      vectors++;
      if (obs_lat != exp_lat) begin
        miscompares++;
        $display("FAIL rand_latency[%0d] op=%0d: got %0d required %0d", i, op, obs_lat, exp_lat);
      end
      vectors++;
      if ({obs_we, obs_dw, obs_rw, obs_zf, obs_cf} !== {exp_we, exp_dw, exp_rw, exp_zf, exp_cf}) begin
        miscompares++;
        $display("FAIL rand_result[%0d] op=%0d a=%0d b=%0d: we/dw/rw/zf/cf got %b/%0d/%0d/%b/%b required %b/%0d/%0d/%b/%b",
                 i, op, a, b, obs_we, obs_dw, obs_rw, obs_zf, obs_cf, exp_we, exp_dw, exp_rw, exp_zf, exp_cf);
      end
      vectors++;
      if ({obs_busy_wb, obs_early, obs_busy_drop, obs_after} !== 6'b100000) begin
        miscompares++;
        $display("FAIL rand_handshake[%0d]: got %b required 100000", i, {obs_busy_wb, obs_early, obs_busy_drop, obs_after});
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_dw = '0; exp_rw = '0; exp_zf = 1'b0; exp_cf = 1'b0; exp_we = 1'b0; exp_lat = 0;
    test_reset();
    test_add_sub();
    test_mul();
    test_nop();
    test_reset_mid_mul();
    test_logic_back_to_back();
    test_start_in_wb();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
